// File: rtl/uart_cfg_ctrl_pkg.sv
// Shared UART configuration types: frame format, baud select, baud-generator and RX sampling settings.
// Also holds the baud table helper and the legality check for a configuration write.
package uart_cfg_ctrl_pkg;

   typedef struct packed {
      logic       parity_en;
      logic       parity_even;
      logic [3:0] data_len;
      logic [1:0] stop_len;
   } uart_config;

   typedef enum logic [2:0] {
      BAUD_9600, BAUD_19200, BAUD_38400, BAUD_57600,
      BAUD_115200, BAUD_230400, BAUD_460800, BAUD_921600
   } uart_baud_sel;

   typedef enum logic [1:0] {IDLE, DRAIN, COMMIT} uart_cfg_states;

   typedef struct packed {
      uart_baud_sel baud_sel;
      logic [15:0]  tx_clks_per_bit;
      logic [4:0]   rx_clks_per_bit;
   } uart_config_bdgen;

   typedef struct packed {
      logic [4:0] osm;
      logic [3:0] smp_nth;
   } uart_config_rx;

   localparam uart_config UART_CFG_DEFAULT =
      '{parity_en: 1'b0, parity_even: 1'b0, data_len: 4'd8, stop_len: 2'd0};
   localparam uart_baud_sel UART_BAUD_DEFAULT = BAUD_115200;

   function automatic int unsigned baud_rate(uart_baud_sel sel);
      case (sel)
         BAUD_9600:   return 9600;
         BAUD_19200:  return 19200;
         BAUD_38400:  return 38400;
         BAUD_57600:  return 57600;
         BAUD_115200: return 115200;
         BAUD_230400: return 230400;
         BAUD_460800: return 460800;
         default:     return 921600;
      endcase
   endfunction

   // Rounded to nearest so the bit period error is at most half a clock.
   function automatic int unsigned calc_clks_per_bit(int unsigned clk_freq, uart_baud_sel baud_sel);
      int unsigned b;
      b = baud_rate(baud_sel);
      return (clk_freq + b / 2) / b;
   endfunction

   function automatic logic cfg_legal(uart_config c);
      return (c.data_len >= 4'd5) && (c.data_len <= 4'd8) && (c.stop_len <= 2'd1);
   endfunction

endpackage

// File: rtl/uart_cfg_ctrl.sv
// Shadows a validated config write, stalls TX and waits QUIET_CYCLES idle cycles, then commits all outputs at once.
// Commit lands QUIET_CYCLES+1 cycles after accept when idle; wr_ready is low from accept until the cycle after commit.
module uart_cfg_ctrl
   import uart_cfg_ctrl_pkg::*;
#(
   parameter int unsigned CLK_FREQ     = 100_000_000,
   parameter int          OSM          = 16,
   parameter int          QUIET_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  uart_config       wr_cfg,
   input  logic [2:0]       wr_baud_sel,
   input  logic             tx_busy,
   input  logic             rx_busy,
   output logic             hold_tx,
   output uart_config       cfg,
   output uart_config_bdgen bdgen,
   output uart_config_rx    rx_cfg,
   output logic             cfg_update,
   output logic             cfg_err
);

   typedef logic [7:0][15:0] cpb_tab_t;

   function automatic cpb_tab_t build_cpb_tab(int unsigned f);
      cpb_tab_t t;
      for (int i = 0; i < 8; i++) t[i] = 16'(calc_clks_per_bit(f, uart_baud_sel'(3'(i))));
      return t;
   endfunction

   localparam cpb_tab_t   CPB_TAB     = build_cpb_tab(CLK_FREQ);
   localparam logic [3:0] SMP_NTH     = (OSM / 2 > 15) ? 4'd15 : 4'(OSM / 2);
   localparam logic [7:0] QUIET_LAST  = 8'(QUIET_CYCLES - 1);
   localparam uart_config_bdgen BDGEN_DEFAULT =
      '{baud_sel: UART_BAUD_DEFAULT, tx_clks_per_bit: CPB_TAB[UART_BAUD_DEFAULT], rx_clks_per_bit: 5'(OSM)};

   if (OSM < 4 || OSM > 31) begin : g_bad_osm
      $error("uart_cfg_ctrl: OSM must be within 4..31");
   end
   if (QUIET_CYCLES < 1 || QUIET_CYCLES > 256) begin : g_bad_quiet
      $error("uart_cfg_ctrl: QUIET_CYCLES must be within 1..256");
   end
   for (genvar i = 0; i < 8; i++) begin : g_cpb_chk
      if (calc_clks_per_bit(CLK_FREQ, uart_baud_sel'(3'(i))) > 32'd65535) begin : g_ovf
         $error("uart_cfg_ctrl: clocks per bit does not fit in 16 bits");
      end
   end

   uart_cfg_states   state_q;
   logic [7:0]       cnt_q, cnt_d;
   uart_config       shadow_cfg_q, cfg_q;
   uart_baud_sel     shadow_sel_q;
   uart_config_bdgen bdgen_q;
   logic             cfg_update_q, cfg_err_q;
   logic             quiet, quiet_done;

   always_comb begin
      quiet      = !tx_busy && !rx_busy;
      cnt_d      = quiet ? cnt_q + 8'd1 : 8'd0;
      quiet_done = quiet && (cnt_q == QUIET_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= 8'd0;
         shadow_cfg_q <= UART_CFG_DEFAULT;
         shadow_sel_q <= UART_BAUD_DEFAULT;
         cfg_q        <= UART_CFG_DEFAULT;
         bdgen_q      <= BDGEN_DEFAULT;
         cfg_update_q <= 1'b0;
         cfg_err_q    <= 1'b0;
      end else begin
         cfg_update_q <= 1'b0;
         cfg_err_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (wr_valid) begin
                  if (cfg_legal(wr_cfg)) begin
                     shadow_cfg_q <= wr_cfg;
                     shadow_sel_q <= uart_baud_sel'(wr_baud_sel);
                     cnt_q        <= 8'd0;
                     state_q      <= DRAIN;
                  end else begin
                     cfg_err_q <= 1'b1;
                  end
               end
            end
            DRAIN: begin
               // Outputs load on the edge into COMMIT so cfg_update aligns with new values.
               if (quiet_done) begin
                  cnt_q        <= 8'd0;
                  state_q      <= COMMIT;
                  cfg_q        <= shadow_cfg_q;
                  bdgen_q      <= '{baud_sel: shadow_sel_q,
                                    tx_clks_per_bit: CPB_TAB[shadow_sel_q],
                                    rx_clks_per_bit: 5'(OSM)};
                  cfg_update_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            COMMIT:  state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign wr_ready   = (state_q == IDLE);
   assign hold_tx    = (state_q != IDLE);
   assign cfg        = cfg_q;
   assign bdgen      = bdgen_q;
   assign rx_cfg     = '{osm: 5'(OSM), smp_nth: SMP_NTH};
   assign cfg_update = cfg_update_q;
   assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_uart_cfg_ctrl.sv
// Scoreboard bench for uart_cfg_ctrl: expected commits/rejects queued at drive time, popped on cfg_update/cfg_err.
module tb_uart_cfg_ctrl;
   import uart_cfg_ctrl_pkg::*;

   localparam int Q = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             wr_valid, wr_ready;
   uart_config       wr_cfg;
   logic [2:0]       wr_baud_sel;
   logic             tx_busy, rx_busy, hold_tx;
   uart_config       cfg;
   uart_config_bdgen bdgen;
   uart_config_rx    rx_cfg;
   logic             cfg_update, cfg_err;

   uart_cfg_ctrl #(.CLK_FREQ(100_000_000), .OSM(16), .QUIET_CYCLES(Q)) dut (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_cfg(wr_cfg), .wr_baud_sel(wr_baud_sel), .tx_busy(tx_busy), .rx_busy(rx_busy),
      .hold_tx(hold_tx), .cfg(cfg), .bdgen(bdgen), .rx_cfg(rx_cfg),
      .cfg_update(cfg_update), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic        is_err;
      uart_config  cfg;
      logic [15:0] cpb;
   } exp_t;
   exp_t sb[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic uart_config mk(input logic pe, input logic pv, input int dl, input int sl);
      uart_config c;
      c.parity_en   = pe;
      c.parity_even = pv;
      c.data_len    = 4'(dl);
      c.stop_len    = 2'(sl);
      return c;
   endfunction

   function automatic logic [15:0] ref_cpb(input int sel);
      int unsigned b;
      case (sel)
         0: b = 9600;   1: b = 19200;  2: b = 38400;  3: b = 57600;
         4: b = 115200; 5: b = 230400; 6: b = 460800; default: b = 921600;
      endcase
      return 16'((32'd100_000_000 + b / 2) / b);
   endfunction

   task automatic offer(input uart_config c, input int sel);
      exp_t e;
      wr_valid    = 1'b1;
      wr_cfg      = c;
      wr_baud_sel = 3'(sel);
      e.is_err = !((c.data_len >= 5) && (c.data_len <= 8) && (c.stop_len <= 1));
      e.cfg    = c;
      e.cpb    = ref_cpb(sel);
      sb.push_back(e);
   endtask

   // Scoreboard consumer and "outputs only change on commit" watcher.
   uart_config  prev_cfg;
   logic [15:0] prev_cpb;
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (cfg_update || cfg_err) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected", 32'({cfg_update, cfg_err}), 32'd0);
            end else begin
               e = sb.pop_front();
               chk("sb_err", 32'(cfg_err), 32'(e.is_err));
               chk("sb_upd", 32'(cfg_update), 32'(!e.is_err));
               if (!e.is_err) begin
                  chk("sb_cfg", 32'(cfg), 32'(e.cfg));
                  chk("sb_cpb", 32'(bdgen.tx_clks_per_bit), 32'(e.cpb));
               end
            end
         end
         chk("stable", 32'(!cfg_update && (cfg != prev_cfg || bdgen.tx_clks_per_bit != prev_cpb)), 32'd0);
      end
      prev_cfg = cfg;
      prev_cpb = bdgen.tx_clks_per_bit;
   end

   int n_upd;

   initial begin
      rst_n = 1'b1; wr_valid = 1'b0; wr_cfg = mk(0, 0, 8, 0); wr_baud_sel = 3'd0;
      tx_busy = 1'b0; rx_busy = 1'b0;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_cfg", 32'(cfg), 32'(mk(0, 0, 8, 0)));
      chk("rst_cpb", 32'(bdgen.tx_clks_per_bit), 32'd868);
      chk("rst_rxclk", 32'(bdgen.rx_clks_per_bit), 32'd16);
      chk("rst_osm", 32'(rx_cfg.osm), 32'd16);
      chk("rst_smp", 32'(rx_cfg.smp_nth), 32'd8);
      chk("rst_rdy", 32'(wr_ready), 32'd1);
      chk("rst_hold", 32'(hold_tx), 32'd0);
      chk("rst_upd", 32'(cfg_update), 32'd0);
      chk("rst_err", 32'(cfg_err), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Latency with both busy lines low.
      offer(mk(1, 1, 7, 1), 0);
      for (int c = 1; c <= Q + 2; c++) begin
         @(negedge clk);
         wr_valid = 1'b0;
         chk("lat_hold", 32'(hold_tx), 32'(c <= Q + 1));
         chk("lat_rdy", 32'(wr_ready), 32'(c == Q + 2));
         chk("lat_upd", 32'(cfg_update), 32'(c == Q + 1));
         chk("lat_cfg", 32'(cfg), (c <= Q) ? 32'(mk(0, 0, 8, 0)) : 32'(mk(1, 1, 7, 1)));
         chk("lat_cpb", 32'(bdgen.tx_clks_per_bit), (c <= Q) ? 32'd868 : 32'd10417);
      end

      // Illegal writes: consumed, one error pulse each, nothing else moves.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         offer((k == 0) ? mk(0, 1, 9, 0) : (k == 1) ? mk(1, 0, 4, 1) : mk(0, 0, 8, 2), 3);
         @(negedge clk);
         wr_valid = 1'b0;
         chk("ill_err", 32'(cfg_err), 32'd1);
         chk("ill_rdy", 32'(wr_ready), 32'd1);
         chk("ill_hold", 32'(hold_tx), 32'd0);
         chk("ill_cfg", 32'(cfg), 32'(mk(1, 1, 7, 1)));
         @(negedge clk);
         chk("ill_err_clr", 32'(cfg_err), 32'd0);
      end

      // tx_busy rising with the accept for 10 cycles, then an rx_busy glitch at cycle 12.
      @(negedge clk);
      offer(mk(0, 1, 5, 0), 2);
      tx_busy = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         wr_valid = 1'b0;
         chk("busy_upd", 32'(cfg_update), 32'(c == 12 + Q + 1));
         chk("busy_hold", 32'(hold_tx), 32'(c <= 12 + Q + 1));
         tx_busy = (c <= 10);
         rx_busy = (c == 12);
      end
      chk("busy_cpb", 32'(bdgen.tx_clks_per_bit), 32'd2604);

      // RX permanently busy stalls DRAIN until released.
      offer(mk(1, 0, 6, 1), 5);
      rx_busy = 1'b1;
      for (int c = 1; c <= 64; c++) begin
         @(negedge clk);
         wr_valid = 1'b0;
         chk("stall_upd", 32'(cfg_update), 32'(c == 59 + Q + 1));
         chk("stall_hold", 32'(hold_tx), 32'(c <= 59 + Q + 1));
         rx_busy = (c < 60);
      end
      chk("stall_cfg", 32'(cfg), 32'(mk(1, 0, 6, 1)));
      chk("stall_cpb", 32'(bdgen.tx_clks_per_bit), 32'd434);

      // Reset in the middle of DRAIN: async return to defaults, shadow discarded.
      offer(mk(0, 0, 6, 0), 7);
      @(negedge clk);
      wr_valid = 1'b0;
      chk("mid_hold", 32'(hold_tx), 32'd1);
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk("arst_cfg", 32'(cfg), 32'(mk(0, 0, 8, 0)));
      chk("arst_cpb", 32'(bdgen.tx_clks_per_bit), 32'd868);
      chk("arst_hold", 32'(hold_tx), 32'd0);
      chk("arst_rdy", 32'(wr_ready), 32'd1);
      chk("arst_upd", 32'(cfg_update), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("post_rst_cfg", 32'(cfg), 32'(mk(0, 0, 8, 0)));
      offer(mk(1, 1, 8, 1), 7);
      for (int c = 1; c <= Q + 2; c++) begin
         @(negedge clk);
         wr_valid = 1'b0;
         chk("rw_upd", 32'(cfg_update), 32'(c == Q + 1));
         chk("rw_rdy", 32'(wr_ready), 32'(c == Q + 2));
      end
      chk("rw_cpb", 32'(bdgen.tx_clks_per_bit), 32'd109);

      // wr_valid held across a commit: second write accepted only when wr_ready returns.
      @(negedge clk);
      offer(mk(0, 0, 7, 0), 1);
      n_upd = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (cfg_update) n_upd++;
         chk("b2b_rdy", 32'(wr_ready), 32'(c == Q + 2 || c >= 2 * Q + 4));
         chk("b2b_hold", 32'(hold_tx), 32'((c <= Q + 1) || (c >= Q + 3 && c <= 2 * Q + 3)));
         chk("b2b_upd", 32'(cfg_update), 32'(c == Q + 1 || c == 2 * Q + 3));
         if (c == 1) offer(mk(1, 1, 5, 1), 6);
         if (c == Q + 3) wr_valid = 1'b0;
      end
      chk("b2b_pulses", 32'(n_upd), 32'd2);
      chk("b2b_cpb", 32'(bdgen.tx_clks_per_bit), 32'd217);

      repeat (3) @(negedge clk);
      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_cfg_ctrl.md
# uart_cfg_ctrl

Configuration controller for the UART core. It accepts runtime configuration writes over a valid/ready port and checks them. It holds the new settings in a shadow register, stalls new TX frames, and waits until both TX and RX are quiet. It then commits frame format, baud divisor and RX sampling settings atomically to the transmitter, receiver and baud generator.

## Interface
Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- OSM, 16: RX oversampling factor. Legal range is 4..31.
- QUIET_CYCLES, 2: consecutive cycles with TX and RX both idle that are required before a commit. Minimum is 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_valid  in  1  a configuration write is offered.
- wr_ready  out  1  the controller can accept a write.
- wr_cfg  in  uart_config (8)  requested parity_en, parity_even, data_len and stop_len.
- wr_baud_sel  in  3  baud rate select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5=230400, 6=460800, 7=921600.
- tx_busy  in  1  the transmitter is mid-frame.
- rx_busy  in  1  the receiver is mid-frame.
- hold_tx  out  1  the transmitter must not start a new frame.
- cfg  out  uart_config  active frame format.
- bdgen  out  uart_config_bdgen  active baud generator settings.
- rx_cfg  out  uart_config_rx  active RX sampling settings.
- cfg_update  out  1  one-cycle pulse, high in the cycle new settings first appear on the outputs.
- cfg_err  out  1  one-cycle pulse indicating a write was rejected.

## Operation
- States of the FSM are IDLE, DRAIN and COMMIT. The state type is uart_cfg_states.
- IDLE:
  - wr_ready=1.
  - A write is accepted on any clock edge where wr_valid and wr_ready are both high.
- Validation:
  - A write is legal when data_len is in 5..8 and stop_len is in 0..1.
  - A legal write latches wr_cfg and wr_baud_sel into the shadow register and moves the FSM to DRAIN.
  - An illegal write is consumed. It raises cfg_err for the next cycle, leaves the shadow and outputs unchanged, and keeps the FSM in IDLE.
- DRAIN:
  - wr_ready=0.
  - The 8-bit quiet counter starts from 0 when DRAIN is entered.
  - The counter increments in each cycle where tx_busy and rx_busy are both 0. It clears in any cycle where either is 1.
  - If the counter equals QUIET_CYCLES-1 and both busy inputs are 0, the next state is COMMIT.
- COMMIT:
  - Lasts exactly one cycle and always returns to IDLE.
  - The output registers load from the shadow register on the edge that enters COMMIT.
  - cfg_update=1 for the whole COMMIT cycle.
- hold_tx is the combinational term (state != IDLE).
- bdgen.tx_clks_per_bit is (CLK_FREQ + baud/2) / baud, computed at elaboration. Every entry must fit in 16 bits, checked by an elaboration assertion.
- bdgen.rx_clks_per_bit is OSM. The baud generator derives the sample tick as tx_clks_per_bit/OSM.
- rx_cfg.osm is OSM. rx_cfg.smp_nth is OSM/2, truncated and clamped to 15.
- Writes that arrive outside IDLE are not accepted. The requester holds wr_valid high until wr_ready is high.

## Timing
Reset values:
- cfg = {parity_en 0, parity_even 0, data_len 8, stop_len 0}.
- bdgen uses baud_sel 4, giving tx_clks_per_bit 868 at 100 MHz, and rx_clks_per_bit OSM.
- rx_cfg = {OSM, OSM/2}.
- wr_ready=1, hold_tx=0, cfg_update=0, cfg_err=0, state IDLE, counter 0.

Latency:
- With both busy inputs low throughout, a write accepted at edge 0 gives DRAIN in cycles 1..QUIET_CYCLES.
- COMMIT is cycle QUIET_CYCLES+1, and the new outputs and cfg_update appear in that cycle.
- wr_ready returns high in cycle QUIET_CYCLES+2.

Boundary cases:
- If tx_busy rises in the same cycle as the accept, that frame completes under the old settings. DRAIN waits for it to finish.
- A busy glitch during DRAIN restarts the quiet count from 0.
- DRAIN has no timeout. A permanently busy RX stalls the controller, and the bench must observe this.
- Reset asserted at any point discards the shadow register and forces all outputs to their reset values immediately, with no clock edge required.
- Outputs never change except in the COMMIT cycle or on reset.

## Structure
Additions to the shared uart_config package:
- enum uart_baud_sel.
- enum uart_cfg_states {IDLE, DRAIN, COMMIT}.
- function calc_clks_per_bit(clk_freq, baud_sel).
- Constants UART_CFG_DEFAULT and UART_BAUD_DEFAULT.

The block has no sub-module. The baud table is a package function, and the quiet counter is inline.

## Test plan
- Reset with defaults → cfg={0,0,8,0}, bdgen.tx_clks_per_bit=868, rx_cfg={16,8}, wr_ready=1, hold_tx=0.
- Legal write {1,1,7,1} with baud_sel 0, both busy inputs low → hold_tx high from cycle 1, cfg_update pulse and cfg={1,1,7,1} with tx_clks_per_bit=10417 in cycle 3, wr_ready high in cycle 4.
- Legal write with tx_busy high for 10 cycles after the accept and an rx_busy pulse at cycle 12 → commit occurs exactly QUIET_CYCLES idle cycles after the last busy cycle, and hold_tx stays high throughout.
- Illegal writes with data_len=9, then data_len=4, then stop_len=2 → one cfg_err pulse each, outputs unchanged, wr_ready stays 1.
- Reset asserted mid-DRAIN after a write with baud_sel 7 → outputs return to their reset values asynchronously, no cfg_update pulse, and the next write behaves normally.
- Back-to-back wr_valid held high through a commit → the second write is accepted only in the cycle wr_ready returns high, and each commit produces exactly one cfg_update pulse.
